// File: rtl/axi_rd_arbiter_2x1.sv
// axi_rd_arbiter_2x1
// Two-requester round-robin arbiter for one AXI4 read master port (AR + R).
// One burst is in flight at a time. The grant is held from AR acceptance
// until the R beat carrying rlast completes.
// Optional beat counters are enabled by defining AXI_RD_ARB_PERF_EN.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no burst owned; sample both arvalids and pick the winner
// ADDR  | granted AR is presented on m00; wait for the AR handshake
// DATA  | R beats are routed to the granted requester until rlast

module axi_rd_arbiter_2x1 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ID_WIDTH-1:0]   s00_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s00_axi_araddr,
    input  logic [7:0]            s00_axi_arlen,
    input  logic                  s00_axi_arvalid,
    output logic                  s00_axi_arready,
    output logic [ID_WIDTH-1:0]   s00_axi_rid,
    output logic [DATA_WIDTH-1:0] s00_axi_rdata,
    output logic [1:0]            s00_axi_rresp,
    output logic                  s00_axi_rlast,
    output logic                  s00_axi_rvalid,
    input  logic                  s00_axi_rready,

    input  logic [ID_WIDTH-1:0]   s01_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s01_axi_araddr,
    input  logic [7:0]            s01_axi_arlen,
    input  logic                  s01_axi_arvalid,
    output logic                  s01_axi_arready,
    output logic [ID_WIDTH-1:0]   s01_axi_rid,
    output logic [DATA_WIDTH-1:0] s01_axi_rdata,
    output logic [1:0]            s01_axi_rresp,
    output logic                  s01_axi_rlast,
    output logic                  s01_axi_rvalid,
    input  logic                  s01_axi_rready,

    output logic [ID_WIDTH-1:0]   m00_axi_arid,
    output logic [ADDR_WIDTH-1:0] m00_axi_araddr,
    output logic [7:0]            m00_axi_arlen,
    output logic                  m00_axi_arvalid,
    input  logic                  m00_axi_arready,
    input  logic [ID_WIDTH-1:0]   m00_axi_rid,
    input  logic [DATA_WIDTH-1:0] m00_axi_rdata,
    input  logic [1:0]            m00_axi_rresp,
    input  logic                  m00_axi_rlast,
    input  logic                  m00_axi_rvalid,
    output logic                  m00_axi_rready,

    output logic                  busy
`ifdef AXI_RD_ARB_PERF_EN
    ,
    output logic [31:0]           s00_rd_beats,
    output logic [31:0]           s01_rd_beats
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_grant;
    logic   w_grant_nxt;
    logic   r_last_grant;
    logic   w_last_grant_nxt;

    // Any handshake on the master R channel that closes the burst.
    logic   w_r_last_hs;
    // Master AR handshake for the currently granted requester.
    logic   w_ar_hs;

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    // Next-state decode plus all channel muxing; everything idles at zero.
    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        w_ar_hs          = 1'b0;
        w_r_last_hs      = 1'b0;

        s00_axi_arready  = 1'b0;
        s00_axi_rid      = '0;
        s00_axi_rdata    = '0;
        s00_axi_rresp    = '0;
        s00_axi_rlast    = 1'b0;
        s00_axi_rvalid   = 1'b0;

        s01_axi_arready  = 1'b0;
        s01_axi_rid      = '0;
        s01_axi_rdata    = '0;
        s01_axi_rresp    = '0;
        s01_axi_rlast    = 1'b0;
        s01_axi_rvalid   = 1'b0;

        m00_axi_arid     = '0;
        m00_axi_araddr   = '0;
        m00_axi_arlen    = '0;
        m00_axi_arvalid  = 1'b0;
        m00_axi_rready   = 1'b0;

        busy             = (r_state != ST_IDLE);

        case (r_state)
            ST_IDLE: begin
                // Contested: the requester that did not win last time goes next.
                if (s00_axi_arvalid && s01_axi_arvalid) begin
                    w_grant_nxt = ~r_last_grant;
                    w_state_nxt = ST_ADDR;
                end else if (s00_axi_arvalid) begin
                    w_grant_nxt = 1'b0;
                    w_state_nxt = ST_ADDR;
                end else if (s01_axi_arvalid) begin
                    w_grant_nxt = 1'b1;
                    w_state_nxt = ST_ADDR;
                end
            end

            ST_ADDR: begin
                if (!r_grant) begin
                    m00_axi_arid    = s00_axi_arid;
                    m00_axi_araddr  = s00_axi_araddr;
                    m00_axi_arlen   = s00_axi_arlen;
                    m00_axi_arvalid = s00_axi_arvalid;
                    s00_axi_arready = m00_axi_arready;
                end else begin
                    m00_axi_arid    = s01_axi_arid;
                    m00_axi_araddr  = s01_axi_araddr;
                    m00_axi_arlen   = s01_axi_arlen;
                    m00_axi_arvalid = s01_axi_arvalid;
                    s01_axi_arready = m00_axi_arready;
                end
                // A requester that drops arvalid early simply leaves us waiting here.
                w_ar_hs = m00_axi_arvalid && m00_axi_arready;
                if (w_ar_hs) begin
                    w_state_nxt = ST_DATA;
                end
            end

            ST_DATA: begin
                if (!r_grant) begin
                    s00_axi_rid    = m00_axi_rid;
                    s00_axi_rdata  = m00_axi_rdata;
                    s00_axi_rresp  = m00_axi_rresp;
                    s00_axi_rlast  = m00_axi_rlast;
                    s00_axi_rvalid = m00_axi_rvalid;
                    m00_axi_rready = s00_axi_rready;
                end else begin
                    s01_axi_rid    = m00_axi_rid;
                    s01_axi_rdata  = m00_axi_rdata;
                    s01_axi_rresp  = m00_axi_rresp;
                    s01_axi_rlast  = m00_axi_rlast;
                    s01_axi_rvalid = m00_axi_rvalid;
                    m00_axi_rready = s01_axi_rready;
                end
                w_r_last_hs = m00_axi_rvalid && m00_axi_rready && m00_axi_rlast;
                if (w_r_last_hs) begin
                    w_state_nxt      = ST_IDLE;
                    w_last_grant_nxt = r_grant;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef AXI_RD_ARB_PERF_EN
    // Per-requester count of delivered R beats; wraps naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s00_rd_beats <= '0;
            s01_rd_beats <= '0;
        end else begin
            if (s00_axi_rvalid && s00_axi_rready) begin
                s00_rd_beats <= s00_rd_beats + 32'd1;
            end
            if (s01_axi_rvalid && s01_axi_rready) begin
                s01_rd_beats <= s01_rd_beats + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axi_rd_arbiter_2x1.sv
// Self-checking bench for axi_rd_arbiter_2x1: a table of burst records
// (requesters active, addresses, IDs, length, expected winner) followed by
// hand-written backpressure / turnaround, reset and beat-counter sequences.

module tb_axi_rd_arbiter_2x1;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int IW = 8;

    logic          clk;
    logic          rst;

    logic [IW-1:0] s00_axi_arid,  s01_axi_arid,  m00_axi_arid;
    logic [AW-1:0] s00_axi_araddr, s01_axi_araddr, m00_axi_araddr;
    logic [7:0]    s00_axi_arlen, s01_axi_arlen, m00_axi_arlen;
    logic          s00_axi_arvalid, s01_axi_arvalid, m00_axi_arvalid;
    logic          s00_axi_arready, s01_axi_arready, m00_axi_arready;
    logic [IW-1:0] s00_axi_rid,   s01_axi_rid,   m00_axi_rid;
    logic [DW-1:0] s00_axi_rdata, s01_axi_rdata, m00_axi_rdata;
    logic [1:0]    s00_axi_rresp, s01_axi_rresp, m00_axi_rresp;
    logic          s00_axi_rlast, s01_axi_rlast, m00_axi_rlast;
    logic          s00_axi_rvalid, s01_axi_rvalid, m00_axi_rvalid;
    logic          s00_axi_rready, s01_axi_rready, m00_axi_rready;
    logic          busy;
`ifdef AXI_RD_ARB_PERF_EN
    logic [31:0]   s00_rd_beats, s01_rd_beats;
`endif

    int n_checks = 0;
    int n_err    = 0;

    axi_rd_arbiter_2x1 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
        .clk             (clk),
        .rst             (rst),
        .s00_axi_arid    (s00_axi_arid),
        .s00_axi_araddr  (s00_axi_araddr),
        .s00_axi_arlen   (s00_axi_arlen),
        .s00_axi_arvalid (s00_axi_arvalid),
        .s00_axi_arready (s00_axi_arready),
        .s00_axi_rid     (s00_axi_rid),
        .s00_axi_rdata   (s00_axi_rdata),
        .s00_axi_rresp   (s00_axi_rresp),
        .s00_axi_rlast   (s00_axi_rlast),
        .s00_axi_rvalid  (s00_axi_rvalid),
        .s00_axi_rready  (s00_axi_rready),
        .s01_axi_arid    (s01_axi_arid),
        .s01_axi_araddr  (s01_axi_araddr),
        .s01_axi_arlen   (s01_axi_arlen),
        .s01_axi_arvalid (s01_axi_arvalid),
        .s01_axi_arready (s01_axi_arready),
        .s01_axi_rid     (s01_axi_rid),
        .s01_axi_rdata   (s01_axi_rdata),
        .s01_axi_rresp   (s01_axi_rresp),
        .s01_axi_rlast   (s01_axi_rlast),
        .s01_axi_rvalid  (s01_axi_rvalid),
        .s01_axi_rready  (s01_axi_rready),
        .m00_axi_arid    (m00_axi_arid),
        .m00_axi_araddr  (m00_axi_araddr),
        .m00_axi_arlen   (m00_axi_arlen),
        .m00_axi_arvalid (m00_axi_arvalid),
        .m00_axi_arready (m00_axi_arready),
        .m00_axi_rid     (m00_axi_rid),
        .m00_axi_rdata   (m00_axi_rdata),
        .m00_axi_rresp   (m00_axi_rresp),
        .m00_axi_rlast   (m00_axi_rlast),
        .m00_axi_rvalid  (m00_axi_rvalid),
        .m00_axi_rready  (m00_axi_rready),
        .busy            (busy)
`ifdef AXI_RD_ARB_PERF_EN
        ,
        .s00_rd_beats    (s00_rd_beats),
        .s01_rd_beats    (s01_rd_beats)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic          v0;
        logic          v1;
        logic [31:0]   a0;
        logic [31:0]   a1;
        logic [7:0]    id0;
        logic [7:0]    id1;
        logic [7:0]    len;
        logic          g;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one full burst from IDLE; inputs change 1ns after a rising edge.
    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] ea;
        logic [7:0]  eid;
        ea  = v.g ? v.a1 : v.a0;
        eid = v.g ? v.id1 : v.id0;
        s00_axi_arvalid = v.v0; s00_axi_araddr = v.a0; s00_axi_arid = v.id0; s00_axi_arlen = v.len;
        s01_axi_arvalid = v.v1; s01_axi_araddr = v.a1; s01_axi_arid = v.id1; s01_axi_arlen = v.len;
        m00_axi_arready = 1'b0; m00_axi_rvalid = 1'b0; m00_axi_rlast = 1'b0;
        s00_axi_rready = 1'b1; s01_axi_rready = 1'b1;
        #1;
        chk($sformatf("v%0d idle_arvalid", idx), 64'(m00_axi_arvalid), 64'd0);
        chk($sformatf("v%0d idle_arready", idx), 64'({s00_axi_arready, s01_axi_arready}), 64'd0);
        step();
        chk($sformatf("v%0d ar_valid", idx), 64'(m00_axi_arvalid), 64'd1);
        chk($sformatf("v%0d ar_addr", idx), 64'(m00_axi_araddr), 64'(ea));
        chk($sformatf("v%0d ar_id", idx), 64'(m00_axi_arid), 64'(eid));
        chk($sformatf("v%0d ar_len", idx), 64'(m00_axi_arlen), 64'(v.len));
        chk($sformatf("v%0d busy_addr", idx), 64'(busy), 64'd1);
        m00_axi_arready = 1'b1;
        #1;
        chk($sformatf("v%0d arready_pair", idx), 64'({s01_axi_arready, s00_axi_arready}),
            v.g ? 64'd2 : 64'd1);
        step();
        m00_axi_arready = 1'b0;
        for (int b = 0; b <= int'(v.len); b++) begin
            m00_axi_rvalid = 1'b1;
            m00_axi_rdata  = ea + 32'(b);
            m00_axi_rid    = eid;
            m00_axi_rresp  = 2'(b);
            m00_axi_rlast  = (b == int'(v.len));
            #1;
            chk($sformatf("v%0d b%0d rvalid_pair", idx, b), 64'({s01_axi_rvalid, s00_axi_rvalid}),
                v.g ? 64'd2 : 64'd1);
            chk($sformatf("v%0d b%0d rdata", idx, b),
                64'(v.g ? s01_axi_rdata : s00_axi_rdata), 64'(ea + 32'(b)));
            chk($sformatf("v%0d b%0d rid", idx, b), 64'(v.g ? s01_axi_rid : s00_axi_rid), 64'(eid));
            chk($sformatf("v%0d b%0d rresp", idx, b),
                64'(v.g ? s01_axi_rresp : s00_axi_rresp), 64'(b % 4));
            chk($sformatf("v%0d b%0d rlast", idx, b),
                64'(v.g ? s01_axi_rlast : s00_axi_rlast), 64'(b == int'(v.len)));
            chk($sformatf("v%0d b%0d m_rready", idx, b), 64'(m00_axi_rready), 64'd1);
            step();
        end
        m00_axi_rvalid = 1'b0; m00_axi_rlast = 1'b0;
        s00_axi_arvalid = 1'b0; s01_axi_arvalid = 1'b0;
        #1;
        chk($sformatf("v%0d busy_end", idx), 64'(busy), 64'd0);
    endtask

    task automatic idle_inputs();
        s00_axi_arvalid = 1'b0; s00_axi_araddr = '0; s00_axi_arid = '0; s00_axi_arlen = '0;
        s01_axi_arvalid = 1'b0; s01_axi_araddr = '0; s01_axi_arid = '0; s01_axi_arlen = '0;
        s00_axi_rready = 1'b0; s01_axi_rready = 1'b0;
        m00_axi_arready = 1'b0; m00_axi_rid = '0; m00_axi_rdata = '0; m00_axi_rresp = '0;
        m00_axi_rlast = 1'b0; m00_axi_rvalid = 1'b0;
    endtask

    initial begin
        int          beats;
        int          cyc;
        logic        done;
        vec_t        pv;

        // --- burst table: grant order depends on the round-robin pointer ---
        tbl[0] = '{1'b1, 1'b1, 32'h100,  32'h200,  8'hA0, 8'hB0, 8'd0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 32'h0,    32'h200,  8'hA1, 8'hB1, 8'd0, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 32'h1000, 32'h0,    8'hA2, 8'hB2, 8'd3, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 32'h0,    32'h3000, 8'hA3, 8'hB3, 8'd2, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 32'h4000, 32'h4800, 8'hA4, 8'hB4, 8'd0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 32'h4010, 32'h4810, 8'hA5, 8'hB5, 8'd1, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 32'h4020, 32'h4820, 8'hA6, 8'hB6, 8'd0, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 32'h4030, 32'h4830, 8'hA7, 8'hB7, 8'd0, 1'b1};
        tbl[8] = '{1'b1, 1'b1, 32'h4040, 32'h4840, 8'hA8, 8'hB8, 8'd1, 1'b0};
        tbl[9] = '{1'b1, 1'b1, 32'h4050, 32'h4850, 8'hA9, 8'hB9, 8'd0, 1'b1};

        idle_inputs();
        rst = 1'b1;
        #1;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst m_arvalid", 64'(m00_axi_arvalid), 64'd0);
        chk("rst m_rready", 64'(m00_axi_rready), 64'd0);
        chk("rst s_ready_valid",
            64'({s00_axi_arready, s01_axi_arready, s00_axi_rvalid, s01_axi_rvalid}), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_vec(tbl[i], i);
        end

        // --- backpressure on AR then toggling rready, plus turnaround timing ---
        s00_axi_arvalid = 1'b1; s00_axi_araddr = 32'h5000; s00_axi_arid = 8'h55; s00_axi_arlen = 8'd7;
        #1;
        chk("bp N arvalid", 64'(m00_axi_arvalid), 64'd0);
        step();
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp stall%0d arvalid", c), 64'(m00_axi_arvalid), 64'd1);
            chk($sformatf("bp stall%0d araddr", c), 64'(m00_axi_araddr), 64'h5000);
            chk($sformatf("bp stall%0d arready", c), 64'(s00_axi_arready), 64'd0);
            step();
        end
        m00_axi_arready = 1'b1;
        #1;
        chk("bp arready", 64'(s00_axi_arready), 64'd1);
        step();
        m00_axi_arready = 1'b0;
        // Next request queued while this burst runs; it must wait.
        s00_axi_araddr = 32'h6000; s00_axi_arid = 8'h66; s00_axi_arlen = 8'd0;
        beats = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 40) begin
            m00_axi_rvalid = 1'b1;
            m00_axi_rdata  = 32'h5000 + 32'(beats);
            m00_axi_rid    = 8'h55;
            m00_axi_rresp  = 2'd0;
            m00_axi_rlast  = (beats == 7);
            s00_axi_rready = cyc[0];
            #1;
            chk($sformatf("bp c%0d m_rready", cyc), 64'(m00_axi_rready), 64'(cyc[0]));
            chk($sformatf("bp c%0d s00_rvalid", cyc), 64'(s00_axi_rvalid), 64'd1);
            chk($sformatf("bp c%0d s00_arready", cyc), 64'(s00_axi_arready), 64'd0);
            if (s00_axi_rready) begin
                chk($sformatf("bp beat%0d rdata", beats), 64'(s00_axi_rdata), 64'(32'h5000 + 32'(beats)));
                if (beats == 7) done = 1'b1;
                beats++;
            end
            cyc++;
            step();
        end
        chk("bp beat count", 64'(beats), 64'd8);
        m00_axi_rvalid = 1'b0; m00_axi_rlast = 1'b0; s00_axi_rready = 1'b1;
        #1;
        chk("turn M+1 arvalid", 64'(m00_axi_arvalid), 64'd0);
        chk("turn M+1 busy", 64'(busy), 64'd0);
        step();
        chk("turn M+2 arvalid", 64'(m00_axi_arvalid), 64'd1);
        chk("turn M+2 araddr", 64'(m00_axi_araddr), 64'h6000);
        m00_axi_arready = 1'b1;
        step();
        m00_axi_arready = 1'b0;
        s00_axi_arvalid = 1'b0;
        m00_axi_rvalid = 1'b1; m00_axi_rdata = 32'h6000; m00_axi_rid = 8'h66; m00_axi_rlast = 1'b1;
        #1;
        chk("turn beat rdata", 64'(s00_axi_rdata), 64'h6000);
        step();
        m00_axi_rvalid = 1'b0; m00_axi_rlast = 1'b0;

        // --- reset in the middle of a burst; s00 must win the next contest ---
        pv = '{1'b1, 1'b0, 32'h7000, 32'h0, 8'h77, 8'h00, 8'd7, 1'b0};
        s00_axi_arvalid = 1'b1; s00_axi_araddr = pv.a0; s00_axi_arid = pv.id0; s00_axi_arlen = pv.len;
        step();
        m00_axi_arready = 1'b1;
        step();
        m00_axi_arready = 1'b0; s00_axi_arvalid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            m00_axi_rvalid = 1'b1; m00_axi_rdata = 32'h7000 + 32'(b); m00_axi_rid = 8'h77;
            step();
        end
        m00_axi_rdata = 32'h7002;
        s00_axi_arvalid = 1'b1; s00_axi_araddr = 32'h100; s00_axi_arlen = 8'd0;
        s01_axi_arvalid = 1'b1; s01_axi_araddr = 32'h200; s01_axi_arlen = 8'd0;
        m00_axi_arready = 1'b1;
        #1;
        chk("mid rvalid before rst", 64'(s00_axi_rvalid), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid rst s00_rvalid", 64'(s00_axi_rvalid), 64'd0);
        chk("mid rst m_rready", 64'(m00_axi_rready), 64'd0);
        chk("mid rst m_arvalid", 64'(m00_axi_arvalid), 64'd0);
        chk("mid rst arready", 64'({s00_axi_arready, s01_axi_arready}), 64'd0);
        chk("mid rst busy", 64'(busy), 64'd0);
        step();
        rst = 1'b0;
        m00_axi_rvalid = 1'b0; m00_axi_arready = 1'b0;
        #1;
        chk("post rst busy", 64'(busy), 64'd0);
        step();
        chk("post rst winner", 64'(m00_axi_araddr), 64'h100);
        rst = 1'b1;
        #1;
        idle_inputs();
        step();
        rst = 1'b0;

`ifdef AXI_RD_ARB_PERF_EN
        // --- beat counters ---
        #1;
        chk("perf s00 reset", 64'(s00_rd_beats), 64'd0);
        pv = '{1'b1, 1'b0, 32'h8000, 32'h0, 8'hC0, 8'h00, 8'd3, 1'b0};
        run_vec(pv, 100);
        pv = '{1'b0, 1'b1, 32'h0, 32'h9000, 8'h00, 8'hD0, 8'd1, 1'b1};
        run_vec(pv, 101);
        chk("perf s00_rd_beats", 64'(s00_rd_beats), 64'd4);
        chk("perf s01_rd_beats", 64'(s01_rd_beats), 64'd2);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
